uart_bus_master: RTL

- CPU-side initiator for the UART register bus.
- Converts a simple single-beat request/response interface into the AXI-lite-style write and read handshakes carried on the packed 32-bit CPU_to_UART / UART_to_CPU words.
- Sits between the CPU load/store path and the UART; exactly one transaction is outstanding at a time.

---
 rtl/uart_bus_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_bus_master.sv
// CPU-side initiator for the UART register bus: one single-beat request at a time,
// translated into AXI-lite-style handshakes. Define UART_MASTER_TIMEOUT_EN to add the abort timer.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] CPU_to_UART,
    input  logic [31:0] UART_to_CPU
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        aw_done_reg, aw_done_next, w_done_reg, w_done_next;
    logic        timed_out_reg, timed_out_next;
    logic        awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
    logic        req_ready_reg, rsp_valid_reg, rsp_valid_next, rsp_timeout_reg, rsp_timeout_next;
    logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]  rsp_resp_reg, rsp_resp_next;
    logic        accept, busy, timeout_hit;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [7:0]  rdata;
    logic        unused_bits;

    assign awready     = UART_to_CPU[0];
    assign wready      = UART_to_CPU[1];
    assign bvalid      = UART_to_CPU[2];
    assign bresp       = UART_to_CPU[4:3];
    assign arready     = UART_to_CPU[5];
    assign rvalid      = UART_to_CPU[6];
    assign rresp       = UART_to_CPU[8:7];
    assign rdata       = UART_to_CPU[16:9];
    assign unused_bits = ^UART_to_CPU[31:17];

`ifdef UART_MASTER_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt_reg <= '0;
        end else if (busy) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    logic unused_cfg;
    assign unused_cfg  = ^CNT_WIDTH'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        aw_done_next     = aw_done_reg;
        w_done_next      = w_done_reg;
        timed_out_next   = timed_out_reg;
        rsp_valid_next   = 1'b0;
        rsp_timeout_next = 1'b0;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_resp_next    = rsp_resp_reg;
        accept           = 1'b0;
        busy             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    accept         = 1'b1;
                    addr_next      = req_addr;
                    wdata_next     = req_wdata;
                    aw_done_next   = 1'b0;
                    w_done_next    = 1'b0;
                    timed_out_next = 1'b0;
                    state_next     = req_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                busy = 1'b1;
                if (awvalid_reg && awready) aw_done_next = 1'b1;
                if (wvalid_reg && wready)   w_done_next  = 1'b1;
                if (aw_done_next && w_done_next) state_next = WR_B;
            end
            WR_B: begin
                busy = 1'b1;
                if (bready_reg && bvalid) begin
                    rsp_resp_next  = bresp;
                    rsp_rdata_next = 8'h00;
                    state_next     = RESP;
                end
            end
            RD_AR: begin
                busy = 1'b1;
                if (arvalid_reg && arready) state_next = RD_R;
            end
            RD_R: begin
                busy = 1'b1;
                if (rready_reg && rvalid) begin
                    rsp_rdata_next = rdata;
                    rsp_resp_next  = rresp;
                    state_next     = RESP;
                end
            end
            RESP: begin
                rsp_valid_next   = 1'b1;
                rsp_timeout_next = timed_out_reg;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A state-completing handshake in the expiry cycle takes priority over the abort.
        if (busy && (state_next == state_reg) && timeout_hit) begin
            state_next     = RESP;
            rsp_resp_next  = 2'b10;
            rsp_rdata_next = 8'h00;
            timed_out_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            timed_out_reg   <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            req_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            aw_done_reg     <= aw_done_next;
            w_done_reg      <= w_done_next;
            timed_out_reg   <= timed_out_next;
            // Bus strobes are registered from the next state so they appear on entry.
            awvalid_reg     <= (state_next == WR_AW_W) && !aw_done_next;
            wvalid_reg      <= (state_next == WR_AW_W) && !w_done_next;
            bready_reg      <= (state_next == WR_B);
            arvalid_reg     <= (state_next == RD_AR);
            rready_reg      <= (state_next == RD_R);
            req_ready_reg   <= (state_reg == IDLE) && !accept;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_resp_reg    <= rsp_resp_next;
        end
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_resp    = rsp_resp_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign CPU_to_UART = {12'b0, rready_reg, addr_reg, arvalid_reg, 1'b0, wdata_reg,
                          bready_reg, addr_reg, wvalid_reg, awvalid_reg};
endmodule
